cmd_arbiter: RTL and testbench
==============================

# cmd_arbiter

Shares the single command port of `cmd_decoder` between two requesters: the external SPI control path (`spi_in` outputs) and an internal requester (sweep/sequencer engine) using valid/ready. SPI commands carry no backpressure, so they are buffered in a small FIFO. A round-robin scheduler issues one command at a time as a one-cycle `cmd_valid` pulse, followed by a programmable guard gap. The block sits between `spi_in` and `cmd_decoder` in the synthesizer top level.

## Interface
- `CMD_W`, 8, command word width
- `DATA_W`, 16, data word width
- `FIFO_DEPTH`, 4, SPI command FIFO entries; power of two, ≥2
- `GAP`, 2, idle cycles forced after each issued command; 0..15
- `sys_clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `spi_cmd_word` in CMD_W: SPI command
- `spi_data_word` in DATA_W: SPI data
- `spi_cmd_valid` in 1: one-cycle strobe; push into FIFO
- `int_req_valid` in 1: internal request pending
- `int_req_cmd` in CMD_W: internal command
- `int_req_data` in DATA_W: internal data
- `int_req_ready` out 1: internal request accepted this cycle
- `out_cmd_word` out CMD_W: to `cmd_decoder`
- `out_data_word` out DATA_W: to `cmd_decoder`
- `out_cmd_valid` out 1: one-cycle issue strobe
- `spi_overflow` out 1: sticky; an SPI command was dropped
- `busy` out 1: state ≠ IDLE or FIFO not empty

## Operation
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - If neither source requests, stay in IDLE.
  - Otherwise grant one source. Load `out_cmd_word`/`out_data_word`. Pop the FIFO or assert `int_req_ready` (combinational, same cycle). Go to ISSUE.
- ISSUE: `out_cmd_valid`=1 for exactly this cycle.
  - GAP=0: return to IDLE.
  - Otherwise load gap counter with GAP-1 and go to GAP.
- GAP: decrement the counter each cycle. At 0, go to IDLE.
- Round-robin arbitration:
  - A 1-bit `last` register records the source of the most recent grant.
  - When both sources request, grant the source that is not `last`.
  - When one source requests, grant it; `last` still updates.
  - Reset value of `last` = internal, so SPI wins the first tie.
- `int_req_ready` is asserted only in IDLE, and only on a grant to the internal source. The internal requester must hold valid/cmd/data stable until ready.
- FIFO rules:
  - Push on `spi_cmd_valid`.
  - Push while full with no pop in the same cycle: command dropped, `spi_overflow` set.
  - Push while full with a pop in the same cycle: command accepted.
  - Push into an empty FIFO: the entry is visible to the arbiter the next cycle (no bypass).
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB compare. Pointers wrap naturally.
- `spi_overflow` clears only on `rst`.
- Output words hold their last issued value between strobes.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty, `last`=internal.
  - `out_cmd_word`=0, `out_data_word`=0, `out_cmd_valid`=0.
  - `int_req_ready`=0, `spi_overflow`=0, `busy`=0.
- Latency:
  - Grant in cycle N produces `out_cmd_valid` in N+1.
  - SPI strobe in cycle N with an idle arbiter and empty FIFO produces `out_cmd_valid` in N+2.
- Issue period is GAP+2 cycles per command under continuous requests. Maximum sustained rate is one command per GAP+2 cycles.
- `rst` asserted mid-operation:
  - Aborts ISSUE/GAP and empties the FIFO; pending entries are lost.
  - `out_cmd_valid` is low in the cycle after `rst` is sampled.
  - An internal request present during `rst` is not acknowledged.

## Configuration
- `CMD_ARB_STATS_EN` defined:
  - Adds output `spi_grant_cnt` (8 bits) and output `int_grant_cnt` (8 bits).
  - Each saturates at 255 and increments on its source's grant.
  - Both clear on `rst`.
- Not defined: the ports are absent and no counter logic is built. All other behaviour is identical.

## Structure
- Shared package `synth_cmd_pkg`:
  - `cmd_arb_state_t` (IDLE/ISSUE/GAP).
  - `req_src_t` (SRC_SPI/SRC_INT).
  - Default CMD_W/DATA_W constants shared with `spi_in`/`cmd_decoder`.
- One sub-module: `cmd_fifo`, a synchronous FIFO storing {cmd, data}. It exposes `push`, `pop`, `full`, `empty` and the head entry, and handles simultaneous push+pop when full.

## Test plan
- Single SPI strobe (cmd 0x12, data 0xABCD) with the FIFO empty → one `out_cmd_valid` pulse 2 cycles later carrying 0x12/0xABCD; `busy` returns to 0 after the GAP cycles.
- Internal request (cmd 0x21, data 0x0400) with no SPI traffic → `int_req_ready` pulses once; `out_cmd_valid` one cycle later; the held request is not re-issued once valid drops.
- Both sources continuously requesting, GAP=2 → grants alternate SPI, INT, SPI, …; issue strobes every 4 cycles.
- Five SPI strobes back-to-back while the internal source holds the arbiter, FIFO_DEPTH=4 → the 5th is dropped and `spi_overflow`=1; four SPI commands issue in order.
- FIFO full with a pop and push in the same cycle → push accepted, no overflow, order preserved.
- `rst` pulsed during GAP with 2 FIFO entries → no further `out_cmd_valid`; all outputs at reset values; FIFO empty.

Source files
------------

// File: rtl/synth_cmd_pkg.sv
// synth_cmd_pkg
// Shared types and default widths for the synthesizer command path
// (spi_in -> cmd_arbiter -> cmd_decoder).
// Contents:
//   CMD_W_DEF / DATA_W_DEF : default command and data word widths
//   cmd_arb_state_t        : arbiter FSM states (idle, issue, guard gap)
//   req_src_t              : which requester owns a grant
package synth_cmd_pkg;

  localparam int CMD_W_DEF  = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_GAP   = 2'd2
  } cmd_arb_state_t;

  typedef enum logic {
    SRC_SPI = 1'b0,
    SRC_INT = 1'b1
  } req_src_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
// Small synchronous FIFO holding {cmd, data} entries from the SPI path.
// A push while full is accepted only if a pop happens in the same cycle,
// because the pop frees the slot the push writes into.
// Ports:
//   clk, rst   : clock and synchronous active-high reset (empties the FIFO)
//   push       : write push_entry this cycle
//   push_entry : entry to write
//   pop        : retire the head entry this cycle (ignored when empty)
//   head       : oldest entry, valid while empty is low
//   full/empty : occupancy flags
module cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_entry,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; empty gates whether head is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/cmd_arbiter.sv
// cmd_arbiter
// Shares the single cmd_decoder command port between the SPI control path
// (buffered in a FIFO, no backpressure) and an internal valid/ready
// requester. Round-robin scheduling; each grant produces a one-cycle
// out_cmd_valid strobe followed by GAP idle cycles.
// Optional build macro: CMD_ARB_STATS_EN adds saturating 8-bit grant
// counters spi_grant_cnt / int_grant_cnt.
// Ports:
//   sys_clk, rst                   : clock, synchronous active-high reset
//   spi_cmd_word/data_word/valid   : SPI command strobe (pushed into FIFO)
//   int_req_valid/cmd/data         : internal request, held until ready
//   int_req_ready                  : internal request accepted this cycle
//   out_cmd_word/data_word/valid   : command issued to cmd_decoder
//   spi_overflow                   : sticky, an SPI command was dropped
//   busy                           : FSM not idle or FIFO not empty
module cmd_arbiter
  import synth_cmd_pkg::*;
#(
  parameter int CMD_W      = CMD_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 2
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  spi_cmd_word,
  input  logic [DATA_W-1:0] spi_data_word,
  input  logic              spi_cmd_valid,
  input  logic              int_req_valid,
  input  logic [CMD_W-1:0]  int_req_cmd,
  input  logic [DATA_W-1:0] int_req_data,
  output logic              int_req_ready,
  output logic [CMD_W-1:0]  out_cmd_word,
  output logic [DATA_W-1:0] out_data_word,
  output logic              out_cmd_valid,
  output logic              spi_overflow,
  output logic              busy
`ifdef CMD_ARB_STATS_EN
  ,
  output logic [7:0]        spi_grant_cnt,
  output logic [7:0]        int_grant_cnt
`endif
);

  localparam int ENTRY_W = CMD_W + DATA_W;
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  cmd_arb_state_t       state;
  req_src_t             last;
  logic [3:0]           gap_cnt;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [ENTRY_W-1:0]   fifo_head;

  logic                 spi_req;
  logic                 grant_spi;
  logic                 grant_int;

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (sys_clk),
    .rst        (rst),
    .push       (spi_cmd_valid),
    .push_entry ({spi_cmd_word, spi_data_word}),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Grants are only made from IDLE. On a tie the source that did not win
  // last time goes first; rst masks grants so a request pending during
  // reset is never acknowledged.
  assign spi_req   = !fifo_empty;
  assign grant_spi = (state == ARB_IDLE) && !rst && spi_req &&
                     (!int_req_valid || (last == SRC_INT));
  assign grant_int = (state == ARB_IDLE) && !rst && int_req_valid &&
                     (!spi_req || (last == SRC_SPI));

  assign fifo_pop      = grant_spi;
  assign int_req_ready = grant_int;
  assign busy          = (state != ARB_IDLE) || !fifo_empty;

  // Scheduler FSM. out_cmd_valid is raised on the grant edge so it is high
  // for exactly the ISSUE cycle; output words hold between strobes.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      last          <= SRC_INT;
      gap_cnt       <= 4'd0;
      out_cmd_word  <= '0;
      out_data_word <= '0;
      out_cmd_valid <= 1'b0;
    end else begin
      out_cmd_valid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_spi) begin
            out_cmd_word  <= fifo_head[ENTRY_W-1:DATA_W];
            out_data_word <= fifo_head[DATA_W-1:0];
            out_cmd_valid <= 1'b1;
            last          <= SRC_SPI;
            state         <= ARB_ISSUE;
          end else if (grant_int) begin
            out_cmd_word  <= int_req_cmd;
            out_data_word <= int_req_data;
            out_cmd_valid <= 1'b1;
            last          <= SRC_INT;
            state         <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (GAP == 0) begin
            state <= ARB_IDLE;
          end else begin
            gap_cnt <= GAP_LOAD;
            state   <= ARB_GAP;
          end
        end
        ARB_GAP: begin
          if (gap_cnt == 4'd0) state <= ARB_IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // A push that finds the FIFO full with no pop in the same cycle is lost.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      spi_overflow <= 1'b0;
    end else if (spi_cmd_valid && fifo_full && !fifo_pop) begin
      spi_overflow <= 1'b1;
    end
  end

`ifdef CMD_ARB_STATS_EN
  // Per-source grant counters, saturating at 255.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      spi_grant_cnt <= 8'd0;
      int_grant_cnt <= 8'd0;
    end else begin
      if (grant_spi && (spi_grant_cnt != 8'hFF)) spi_grant_cnt <= spi_grant_cnt + 8'd1;
      if (grant_int && (int_grant_cnt != 8'hFF)) int_grant_cnt <= int_grant_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter
// Directed bench for cmd_arbiter (FIFO_DEPTH=4, GAP=2). Expected issued
// commands are queued in the order the round-robin arbiter must issue them
// and checked by a monitor whenever out_cmd_valid is seen.
module tb_cmd_arbiter;

  localparam int CMD_W      = 8;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP        = 2;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic [CMD_W-1:0]  spi_cmd_word = '0;
  logic [DATA_W-1:0] spi_data_word = '0;
  logic              spi_cmd_valid = 1'b0;
  logic              int_req_valid = 1'b0;
  logic [CMD_W-1:0]  int_req_cmd = '0;
  logic [DATA_W-1:0] int_req_data = '0;
  logic              int_req_ready;
  logic [CMD_W-1:0]  out_cmd_word;
  logic [DATA_W-1:0] out_data_word;
  logic              out_cmd_valid;
  logic              spi_overflow;
  logic              busy;
`ifdef CMD_ARB_STATS_EN
  logic [7:0]        spi_grant_cnt;
  logic [7:0]        int_grant_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int issue_cnt  = 0;
  int ready_cnt  = 0;
  int int_idx    = 0;
  int base_cnt   = 0;
  logic [23:0] exp_q[$];
  int          issue_cyc_q[$];
  logic [23:0] exp_e;

  cmd_arbiter #(
    .CMD_W      (CMD_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP        (GAP)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .spi_cmd_word  (spi_cmd_word),
    .spi_data_word (spi_data_word),
    .spi_cmd_valid (spi_cmd_valid),
    .int_req_valid (int_req_valid),
    .int_req_cmd   (int_req_cmd),
    .int_req_data  (int_req_data),
    .int_req_ready (int_req_ready),
    .out_cmd_word  (out_cmd_word),
    .out_data_word (out_data_word),
    .out_cmd_valid (out_cmd_valid),
    .spi_overflow  (spi_overflow),
    .busy          (busy)
`ifdef CMD_ARB_STATS_EN
    ,
    .spi_grant_cnt (spi_grant_cnt),
    .int_grant_cnt (int_grant_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the active edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check_output("idle_within_budget", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge sys_clk) begin
    if (int_req_ready === 1'b1) ready_cnt++;
    if (out_cmd_valid === 1'b1) begin
      issue_cnt++;
      issue_cyc_q.push_back(cyc);
      check_output("sb_expected_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check_output("issue_cmd", 32'(out_cmd_word), 32'(exp_e[23:16]));
        check_output("issue_data", 32'(out_data_word), 32'(exp_e[15:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset with an internal request pending: it must not be acknowledged.
    rst = 1'b1;
    int_req_valid = 1'b1;
    int_req_cmd = 8'h5A;
    int_req_data = 16'h1111;
    tick();
    tick();
    check_output("rst_ready", 32'(int_req_ready), 32'd0);
    check_output("rst_valid", 32'(out_cmd_valid), 32'd0);
    check_output("rst_cmd_word", 32'(out_cmd_word), 32'd0);
    check_output("rst_data_word", 32'(out_data_word), 32'd0);
    check_output("rst_overflow", 32'(spi_overflow), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    int_req_valid = 1'b0;
    tick();

    // Single SPI strobe: issue two cycles later.
    spi_cmd_word = 8'h12;
    spi_data_word = 16'hABCD;
    spi_cmd_valid = 1'b1;
    exp_q.push_back({8'h12, 16'hABCD});
    tick();
    spi_cmd_valid = 1'b0;
    check_output("t1_no_early_valid", 32'(out_cmd_valid), 32'd0);
    check_output("t1_busy", 32'(busy), 32'd1);
    tick();
    check_output("t1_valid_n2", 32'(out_cmd_valid), 32'd1);
    check_output("t1_word", 32'(out_cmd_word), 32'h12);
    check_output("t1_data", 32'(out_data_word), 32'hABCD);
    tick();
    check_output("t1_single_pulse", 32'(out_cmd_valid), 32'd0);
    check_output("t1_hold_word", 32'(out_cmd_word), 32'h12);
    check_output("t1_busy_gap", 32'(busy), 32'd1);
    tick();
    tick();
    check_output("t1_busy_done", 32'(busy), 32'd0);

    // Internal request with no SPI traffic.
    int_req_cmd = 8'h21;
    int_req_data = 16'h0400;
    int_req_valid = 1'b1;
    exp_q.push_back({8'h21, 16'h0400});
    #1;
    check_output("t2_ready", 32'(int_req_ready), 32'd1);
    tick();
    int_req_valid = 1'b0;
    check_output("t2_ready_drop", 32'(int_req_ready), 32'd0);
    check_output("t2_valid", 32'(out_cmd_valid), 32'd1);
    wait_idle(20);
    check_output("t2_ready_pulses", 32'(ready_cnt), 32'd1);
    check_output("t2_issue_cnt", 32'(issue_cnt), 32'd2);

    // Both sources requesting: SPI, INT, SPI, INT, SPI every GAP+2 cycles.
    issue_cyc_q.delete();
    exp_q.push_back({8'h31, 16'h1001});
    exp_q.push_back({8'h41, 16'h2001});
    exp_q.push_back({8'h32, 16'h1002});
    exp_q.push_back({8'h42, 16'h2002});
    exp_q.push_back({8'h33, 16'h1003});
    int_idx = 0;
    for (int c = 0; c < 30; c++) begin
      spi_cmd_valid = (c < 3);
      spi_cmd_word = 8'(8'h31 + c);
      spi_data_word = 16'(16'h1001 + c);
      if (c >= 1 && int_idx < 2) begin
        int_req_valid = 1'b1;
        int_req_cmd = 8'(8'h41 + int_idx);
        int_req_data = 16'(16'h2001 + int_idx);
      end else begin
        int_req_valid = 1'b0;
      end
      #1;
      if (int_req_ready === 1'b1) int_idx++;
      tick();
    end
    spi_cmd_valid = 1'b0;
    int_req_valid = 1'b0;
    wait_idle(20);
    check_output("t3_issue_count", 32'(issue_cyc_q.size()), 32'd5);
    for (int i = 1; i < issue_cyc_q.size(); i++) begin
      check_output("t3_issue_period", 32'(issue_cyc_q[i] - issue_cyc_q[i-1]), 32'(GAP + 2));
    end
    check_output("t3_ready_pulses", 32'(ready_cnt), 32'd3);

    // Five SPI strobes while the internal source holds the arbiter.
    exp_q.push_back({8'h51, 16'h3001});
    for (int k = 0; k < 4; k++) exp_q.push_back({8'(8'h61 + k), 16'(16'h4001 + k)});
    for (int k = 0; k < 5; k++) begin
      spi_cmd_valid = 1'b1;
      spi_cmd_word = 8'(8'h61 + k);
      spi_data_word = 16'(16'h4001 + k);
      int_req_valid = (k == 1);
      int_req_cmd = 8'h51;
      int_req_data = 16'h3001;
      #1;
      if (k == 1) check_output("t4_int_wins_tie", 32'(int_req_ready), 32'd1);
      if (k == 4) check_output("t4_no_overflow_yet", 32'(spi_overflow), 32'd0);
      tick();
    end
    spi_cmd_valid = 1'b0;
    int_req_valid = 1'b0;
    check_output("t4_overflow", 32'(spi_overflow), 32'd1);
    wait_idle(40);
    check_output("t4_issue_cnt", 32'(issue_cnt), 32'd12);
    check_output("t4_overflow_sticky", 32'(spi_overflow), 32'd1);

    // Reset during GAP with two FIFO entries pending.
    exp_q.push_back({8'h71, 16'h5001});
    spi_cmd_word = 8'h72;
    spi_data_word = 16'h5002;
    spi_cmd_valid = 1'b1;
    int_req_cmd = 8'h71;
    int_req_data = 16'h5001;
    int_req_valid = 1'b1;
    #1;
    check_output("t6_ready", 32'(int_req_ready), 32'd1);
    tick();
    int_req_valid = 1'b0;
    spi_cmd_word = 8'h73;
    spi_data_word = 16'h5003;
    tick();
    spi_cmd_valid = 1'b0;
    rst = 1'b1;
    check_output("t6_busy_before_rst", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    base_cnt = issue_cnt;
    check_output("t6_base_cnt", 32'(base_cnt), 32'd13);
    check_output("t6_valid", 32'(out_cmd_valid), 32'd0);
    check_output("t6_cmd_word", 32'(out_cmd_word), 32'd0);
    check_output("t6_data_word", 32'(out_data_word), 32'd0);
    check_output("t6_overflow", 32'(spi_overflow), 32'd0);
    check_output("t6_busy", 32'(busy), 32'd0);
    check_output("t6_ready", 32'(int_req_ready), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check_output("t6_no_issue_after_rst", 32'(issue_cnt), 32'(base_cnt));
    check_output("t6_fifo_empty", 32'(busy), 32'd0);

    // FIFO full with pop and push in the same cycle: push accepted.
    exp_q.push_back({8'h81, 16'h6001});
    for (int k = 0; k < 5; k++) exp_q.push_back({8'(8'h91 + k), 16'(16'h7001 + k)});
    for (int k = 0; k < 5; k++) begin
      spi_cmd_valid = 1'b1;
      spi_cmd_word = 8'(8'h91 + k);
      spi_data_word = 16'(16'h7001 + k);
      int_req_valid = (k == 0);
      int_req_cmd = 8'h81;
      int_req_data = 16'h6001;
      #1;
      if (k == 0) check_output("t5_int_grant", 32'(int_req_ready), 32'd1);
      tick();
    end
    spi_cmd_valid = 1'b0;
    int_req_valid = 1'b0;
    check_output("t5_no_overflow", 32'(spi_overflow), 32'd0);
    wait_idle(60);
    check_output("t5_issue_cnt", 32'(issue_cnt), 32'd19);
    check_output("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
